// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the combinational-read instruction memory: owns the fetch PC and
// buffers {pc, word} in a small FIFO for decode. Optional range-fault checking: IFETCH_FAULT_EN.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MEM_BYTES  = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_out,
`ifdef IFETCH_FAULT_EN
    output logic        ins_fault,
`endif
    output logic [31:0] ins_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_e;

    if ((RESET_PC[1:0] != 2'b00) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (MEM_BYTES < 4)) begin : g_bad_param
        $error("imem_fetch_ctrl: illegal parameter combination");
    end

    state_e             state_q;
    logic [31:0]        fpc_q;
    logic [PTR_W-1:0]   rd_q, wr_q;
    logic [CNT_W-1:0]   count_q;
    logic [31:0]        pc_q   [FIFO_DEPTH];
    logic [31:0]        word_q [FIFO_DEPTH];

    logic        pop;
    logic        fetch;
    logic        fetch_fault;
    logic [31:0] push_word;
    logic [31:0] fpc_d;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : fpc_q;
    assign fpc_d     = imem_addr + 32'd4;

    assign ins_valid = (count_q != '0);
    assign ins_out   = word_q[rd_q];
    assign ins_pc    = pc_q[rd_q];

    assign pop   = ins_valid & ins_ready;
    // A pop or a redirect frees a slot in this same cycle, so a full FIFO can still fetch.
    assign fetch = fetch_en & (state_q == FETCH) & ((count_q < DEPTH_C) | pop | redirect_valid);

`ifdef IFETCH_FAULT_EN
    logic fault_q [FIFO_DEPTH];

    // Compare in 33 bits so an address near 2^32 cannot wrap past the limit.
    assign fetch_fault = ({1'b0, imem_addr} + 33'd3) >= 33'(MEM_BYTES);
    assign push_word   = fetch_fault ? 32'h0000_0013 : imem_data;
    assign ins_fault   = fault_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fault_q[i] <= 1'b0;
        end else if (fetch) begin
            fault_q[wr_q] <= fetch_fault;
        end
    end
`else
    assign fetch_fault = 1'b0;
    assign push_word   = imem_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            fpc_q   <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            // NOTE: the storage is reset too so the head outputs read zero while empty after reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_q[i]   <= '0;
                word_q[i] <= '0;
            end
        end else begin
            if (fetch) begin
                pc_q[wr_q]   <= imem_addr;
                word_q[wr_q] <= push_word;
                wr_q         <= wr_q + 1'b1;
                fpc_q        <= fpc_d;
            end

            if (redirect_valid) begin
                rd_q    <= wr_q;
                count_q <= fetch ? CNT_W'(1) : '0;
                state_q <= FETCH;
                if (!fetch) fpc_q <= imem_addr;
            end else begin
                rd_q <= rd_q + PTR_W'(pop);
                case ({fetch, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end

            // Placed last so a faulting fetch halts even when it came from a redirect.
            if (fetch && fetch_fault) state_q <= HALT;
        end
    end

endmodule
